// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes on both sides.
// N-bit operands are cut into STAGES slices of W = N/STAGES bits. Stage k ripples slice k and
// registers its carry, the not-yet-consumed upper operand bits and the lower sum bits built so far.
// Optional feature macro: RC_PIPE_SUB_EN enables subtraction through the sub port.
// N must be a multiple of STAGES.

module pipe_rc_adder #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned W = N / STAGES;

    logic         adv;
    logic         accept;
    logic [N-1:0] b_eff;
    logic         c0;

`ifdef RC_PIPE_SUB_EN
    // Subtraction as a + ~b + 1
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign c0         = cin;
`endif

    // One global enable: the whole pipe moves only when the output slot is free or draining.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && rst_n;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // InW: operand bits still to be consumed at this stage's input (current slice at bottom).
        localparam int unsigned InW  = N - k * W;
        localparam int unsigned SumW = (k + 1) * W;

        logic [InW-1:0]  a_in;
        logic [InW-1:0]  b_in;
        logic            c_in;
        logic            v_in;
        logic            load;
        logic [W:0]      slice;
        logic [SumW-1:0] sum_d;
        logic [SumW-1:0] sum_q;
        logic            valid_q;
        logic            carry_q;

        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = c0;
            assign v_in  = accept;
            // Producer data is captured only on an accepted transfer.
            assign load  = adv && accept;
            assign sum_d = slice[W-1:0];
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign v_in  = g_stage[k-1].valid_q;
            assign load  = adv;
            assign sum_d = {slice[W-1:0], g_stage[k-1].sum_q};
        end

        // Ripple this stage's W-bit slice
        always_comb begin
            slice = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};
        end

        // Valid bit, carry and assembled sum; everything holds while the pipe is stalled
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                if (adv) begin
                    valid_q <= v_in;
                end
                if (load) begin
                    carry_q <= slice[W];
                    sum_q   <= sum_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int unsigned RemW = InW - W;

            logic [RemW-1:0] a_q;
            logic [RemW-1:0] b_q;

            // Skew registers for the operand slices later stages still need
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_in[InW-1:W];
                    b_q <= b_in[InW-1:W];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (load) begin
                    ovf_q <= (a_in[W-1] ^ b_in[W-1] ^ slice[W-1]) ^ slice[W];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign s         = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_rc_adder.sv
// Scoreboard bench for pipe_rc_adder: the driver pushes reference results on every accepted
// transfer, an independent monitor pops and compares on every output transfer.

module tb_pipe_rc_adder;

    localparam int unsigned N      = 32;
    localparam int unsigned STAGES = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    pipe_rc_adder #(
        .N      (N),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t         expq[$];
    int           checks = 0;
    int           passes = 0;
    bit           lat_mode = 1'b0;
    logic [N+1:0] held;
    bit           stalled = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain modulo-2^N arithmetic on the prepared operands.
    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                   input logic ci, input logic su);
        exp_t         r;
        logic [N-1:0] bb;
        logic         c;
        logic [N:0]   full;
`ifdef RC_PIPE_SUB_EN
        bb = su ? ~bv : bv;
        c  = su ? 1'b1 : ci;
`else
        bb = bv;
        c  = ci;
        if (su) bb = bv;
`endif
        full   = {1'b0, av} + {1'b0, bb} + {{N{1'b0}}, c};
        r.s    = full[N-1:0];
        r.cout = full[N];
        r.ovf  = (av[N-1] == bb[N-1]) && (full[N-1] != av[N-1]);
        r.acc  = 0;
        r.lat  = 1'b0;
        return r;
    endfunction

    function automatic logic [N-1:0] pick();
        logic [N-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(N-1){1'b1}}};
            3:       v = {1'b1, {(N-1){1'b0}}};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // One cycle of stimulus; records the expected result if the transfer will happen.
    task automatic drive(input bit iv, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input bit ci, input bit su, input bit ordy, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = av;
        b         = bv;
        cin       = ci;
        sub       = su;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (acc) begin
            e     = model(av, bv, ci, su);
            e.acc = cyc;
            e.lat = lat_mode;
            expq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    // Monitor: compares every output transfer against the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || !out_valid) begin
                stalled = 1'b0;
            end else begin
                if (stalled) chk("stall_hold", 64'({s, cout, ovf}), 64'(held));
                if (out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        $display("FAIL spurious_output: out_valid with nothing outstanding, s=0x%0h",
                                 s);
                    end else begin
                        e = expq.pop_front();
                        chk("result", 64'({s, cout, ovf}), 64'({e.s, e.cout, e.ovf}));
                        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
                    end
                end
                stalled = !out_ready;
                held    = {s, cout, ovf};
            end
        end
    end

    initial begin : stim
        bit           acc;
        int           c;
        int           i;
        int           n;
        logic [N-1:0] pa[8];
        logic [N-1:0] pb[8];
        bit           pc[8];

        // Reset state
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);

        // Directed vectors, back to back, latency checked
        lat_mode = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc);
        chk("accept_0", 64'(acc), 64'd1);
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc);
        drive(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, acc);
        drive(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1, acc);
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, acc);
        idle(STAGES + 2);
        lat_mode = 1'b0;

        // Eight back-to-back pairs with the consumer stalled for three cycles
        for (int k = 0; k < 8; k++) begin
            pa[k] = $urandom;
            pb[k] = $urandom;
            pc[k] = 1'($urandom_range(0, 1));
        end
        c = 0;
        i = 0;
        while (i < 8 && c < 40) begin
            drive(1'b1, pa[i], pb[i], pc[i], 1'b0,
                  !(c >= STAGES + 1 && c <= STAGES + 3), acc);
            if (c <= STAGES + 4)
                chk("in_ready_stall", 64'(in_ready),
                    64'((c >= STAGES + 1 && c <= STAGES + 3) ? 0 : 1));
            if (acc) i++;
            c++;
        end
        if (i < 8) begin
            checks++;
            $display("FAIL stall_stream_timeout: %0d of 8 accepted", i);
        end
        idle(STAGES + 2);

        // Reset with three transactions in flight
        for (int k = 0; k < 3; k++) drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_in_ready", 64'(in_ready), 64'd1);
        lat_mode = 1'b1;
        drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1, acc);
        idle(STAGES + 2);
        lat_mode = 1'b0;

        // Random traffic with random bubbles and back-pressure
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) < 7, pick(), pick(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
        end

        // Drain with a bounded wait
        n = 0;
        while (expq.size() > 0 && n < 100) begin
            idle(1);
            n++;
        end
        idle(2);
        if (expq.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d results outstanding", expq.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
